// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: launch FSM states and defaults.
package uart_tx_fifo_pkg;

  localparam int unsigned DEF_DEPTH       = 16;
  localparam int unsigned DEF_DATA_W      = 8;
  // Cycles spent waiting for busy to rise before giving up on a launch.
  localparam int unsigned ACK_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side and transmitter-side signals of the UART transmit buffer.
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic                     wr_en_i;
  logic [DATA_W-1:0]        wr_data_i;
  logic                     full_o;
  logic                     empty_o;
  logic [$clog2(DEPTH):0]   level_o;
  logic                     ovf_o;
  logic                     ovf_clr_i;
  logic                     tx_e_o;
  logic [DATA_W-1:0]        tx_d_o;
  logic                     tx_busy_i;

  modport master (
    output wr_en_i, wr_data_i, ovf_clr_i, tx_busy_i,
    input  full_o, empty_o, level_o, ovf_o, tx_e_o, tx_d_o
  );

  modport slave (
    input  wr_en_i, wr_data_i, ovf_clr_i, tx_busy_i,
    output full_o, empty_o, level_o, ovf_o, tx_e_o, tx_d_o
  );

endinterface

// File: rtl/uart_fifo_core.sv
// Circular byte FIFO: storage, pointers, level counter, full/empty and sticky overflow.
module uart_fifo_core
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   ovf_clr,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // A write while full is dropped even when a pop happens on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Level is an independent up/down counter; push+pop together leaves it unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow takes priority over a clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf <= 1'b0;
    end else if (push && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer plus launch FSM feeding a UART transmitter over enable/data/busy.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic           clk,
  input  logic           resetn,
  uart_tx_fifo_if.slave  bus
);

  tx_state_t         state, state_next;
  logic              ack_cnt, ack_cnt_next;
  logic              tx_e, tx_e_next;
  logic [DATA_W-1:0] tx_d, tx_d_next;
  logic [DATA_W-1:0] head;
  logic              launch;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_ovf;
  logic [$clog2(DEPTH):0] fifo_level;

  uart_fifo_core #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_core (
    .clk     (clk),
    .resetn  (resetn),
    .push    (bus.wr_en_i),
    .pop     (launch),
    .ovf_clr (bus.ovf_clr_i),
    .din     (bus.wr_data_i),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .ovf     (fifo_ovf),
    .level   (fifo_level)
  );

  assign bus.full_o  = fifo_full;
  assign bus.empty_o = fifo_empty;
  assign bus.ovf_o   = fifo_ovf;
  assign bus.level_o = fifo_level;
  assign bus.tx_e_o  = tx_e;
  assign bus.tx_d_o  = tx_d;

  // State, ack timer and registered transmitter outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      ack_cnt <= 1'b0;
      tx_e    <= 1'b0;
      tx_d    <= '0;
    end else begin
      state   <= state_next;
      ack_cnt <= ack_cnt_next;
      tx_e    <= tx_e_next;
      tx_d    <= tx_d_next;
    end
  end

  // Launch decision and handshake tracking. Outputs are computed as next-values so
  // tx_e/tx_d stay registered as in the original encoding-based FSM.
  always_comb begin
    state_next   = state;
    ack_cnt_next = ack_cnt;
    tx_e_next    = 1'b0;
    tx_d_next    = tx_d;
    launch       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !bus.tx_busy_i) begin
          launch       = 1'b1;
          tx_e_next    = 1'b1;
          tx_d_next    = head;
          ack_cnt_next = 1'b0;
          state_next   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.tx_busy_i) begin
          state_next = WAIT_DONE;
        end else if (ack_cnt == 1'(ACK_WAIT_CYCLES - 1)) begin
          // Busy never rose: drop this byte and move on.
          state_next = IDLE;
        end else begin
          ack_cnt_next = ack_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model plus directed scenarios.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 8;

  logic clk;
  logic resetn;
  logic auto_mode;
  logic auto_busy;
  logic busy_manual;

  int checks;
  int errors;
  int cyc;
  int last_fall;

  logic [7:0] launched [$];
  int         launch_cyc [$];
  int         launch_fall [$];

  uart_tx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  assign bus.tx_busy_i = auto_mode ? auto_busy : busy_manual;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transmitter stand-in: busy rises the cycle after it sees enable and lasts 10 cycles.
  initial begin : tx_model
    int  cnt;
    bit  pend;
    cnt       = 0;
    pend      = 1'b0;
    auto_busy = 1'b0;
    last_fall = -100;
    forever begin
      @(negedge clk);
      if (!auto_mode) begin
        auto_busy = 1'b0;
        cnt       = 0;
        pend      = 1'b0;
      end else begin
        if (pend) begin
          auto_busy = 1'b1;
          cnt       = 10;
          pend      = 1'b0;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            auto_busy = 1'b0;
            last_fall = cyc;
          end
        end
        if (bus.tx_e_o === 1'b1) pend = 1'b1;
      end
    end
  end

  // Reference model: FIFO as a queue, launcher as free/awaiting-busy/busy phases.
  initial begin : compare
    logic [7:0] q [$];
    int         phase;
    int         age;
    logic       m_ovf;
    logic       m_tx_e;
    logic [7:0] m_tx_d;
    logic       m_full;
    logic       s_rst, s_wr, s_clr, s_busy;
    logic [7:0] s_data;
    phase  = 0;
    age    = 0;
    m_ovf  = 1'b0;
    m_tx_e = 1'b0;
    m_tx_d = 8'h00;
    cyc    = 0;
    forever begin
      @(posedge clk);
      s_rst  = resetn;
      s_wr   = bus.wr_en_i;
      s_clr  = bus.ovf_clr_i;
      s_busy = bus.tx_busy_i;
      s_data = bus.wr_data_i;
      cyc++;
      if (!s_rst) begin
        q.delete();
        m_ovf  = 1'b0;
        m_tx_e = 1'b0;
        m_tx_d = 8'h00;
        phase  = 0;
        age    = 0;
      end else begin
        m_full = (q.size() == DEPTH);
        m_tx_e = 1'b0;
        case (phase)
          0: if (q.size() != 0 && !s_busy) begin
               m_tx_d = q.pop_front();
               m_tx_e = 1'b1;
               phase  = 1;
               age    = 0;
             end
          1: begin
               age++;
               if (s_busy)        phase = 2;
               else if (age >= 2) phase = 0;
             end
          default: if (!s_busy) phase = 0;
        endcase
        if (s_wr && m_full) m_ovf = 1'b1;
        else if (s_clr)     m_ovf = 1'b0;
        if (s_wr && !m_full) q.push_back(s_data);
      end
      #1;
      chk("model_level", 32'(bus.level_o), 32'(q.size()));
      chk("model_empty", 32'(bus.empty_o), 32'(q.size() == 0));
      chk("model_full",  32'(bus.full_o),  32'(q.size() == DEPTH));
      chk("model_ovf",   32'(bus.ovf_o),   32'(m_ovf));
      chk("model_tx_e",  32'(bus.tx_e_o),  32'(m_tx_e));
      chk("model_tx_d",  32'(bus.tx_d_o),  32'(m_tx_d));
      if (bus.tx_e_o === 1'b1) begin
        launched.push_back(bus.tx_d_o);
        launch_cyc.push_back(cyc);
        launch_fall.push_back(last_fall);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n0;
    int k;
    bit seen;
    checks          = 0;
    errors          = 0;
    resetn          = 1'b0;
    auto_mode       = 1'b0;
    busy_manual     = 1'b0;
    bus.wr_en_i     = 1'b1;
    bus.wr_data_i   = 8'hEE;
    bus.ovf_clr_i   = 1'b0;

    // Reset held with a write strobe active: nothing may be stored.
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(bus.empty_o), 32'd1);
    chk("rst_level", 32'(bus.level_o), 32'd0);
    chk("rst_tx_e",  32'(bus.tx_e_o),  32'd0);
    chk("rst_tx_d",  32'(bus.tx_d_o),  32'd0);
    chk("rst_ovf",   32'(bus.ovf_o),   32'd0);
    bus.wr_en_i = 1'b0;
    resetn      = 1'b1;
    @(negedge clk);
    chk("rst_nothing_stored", 32'(bus.level_o), 32'd0);

    // Single byte with idle transmitter: pulse on the edge after the write.
    bus.wr_data_i = 8'hA5;
    bus.wr_en_i   = 1'b1;
    @(negedge clk);
    bus.wr_en_i = 1'b0;
    chk("single_level_after_write", 32'(bus.level_o), 32'd1);
    chk("single_no_pulse_yet",      32'(bus.tx_e_o),  32'd0);
    @(negedge clk);
    chk("single_pulse", 32'(bus.tx_e_o),  32'd1);
    chk("single_data",  32'(bus.tx_d_o),  32'hA5);
    chk("single_level", 32'(bus.level_o), 32'd0);
    @(negedge clk);
    chk("single_pulse_one_cycle", 32'(bus.tx_e_o), 32'd0);
    chk("single_data_held",       32'(bus.tx_d_o), 32'hA5);
    repeat (4) @(negedge clk);

    // Burst into a busy transmitter, then overflow, then drain in order.
    busy_manual = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_data_i = 8'(i);
      bus.wr_en_i   = 1'b1;
      @(negedge clk);
    end
    bus.wr_en_i = 1'b0;
    chk("burst_full",  32'(bus.full_o),  32'd1);
    chk("burst_level", 32'(bus.level_o), 32'd16);
    bus.wr_data_i = 8'h55;
    bus.wr_en_i   = 1'b1;
    @(negedge clk);
    bus.wr_en_i = 1'b0;
    chk("burst_ovf",        32'(bus.ovf_o),   32'd1);
    chk("burst_level_held", 32'(bus.level_o), 32'd16);
    n0        = launched.size();
    auto_mode = 1'b1;
    for (int c = 0; c < 600 && launched.size() < n0 + 16; c++) @(negedge clk);
    chk("burst_drain_count", 32'(launched.size() - n0), 32'd16);
    for (int i = 0; i < 16 && n0 + i < launched.size(); i++)
      chk("burst_order", 32'(launched[n0 + i]), 32'(i));
    repeat (30) @(negedge clk);
    chk("burst_drained_empty", 32'(bus.empty_o), 32'd1);
    bus.ovf_clr_i = 1'b1;
    @(negedge clk);
    bus.ovf_clr_i = 1'b0;
    chk("burst_ovf_clear", 32'(bus.ovf_o), 32'd0);

    // Full FIFO, launch and write on the same edge: write is dropped.
    auto_mode   = 1'b0;
    busy_manual = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      bus.wr_data_i = 8'($urandom_range(0, 255));
      bus.wr_en_i   = 1'b1;
      @(negedge clk);
    end
    bus.wr_en_i = 1'b0;
    chk("fullpop_full", 32'(bus.full_o), 32'd1);
    busy_manual   = 1'b0;
    bus.wr_data_i = 8'h77;
    bus.wr_en_i   = 1'b1;
    @(negedge clk);
    bus.wr_en_i = 1'b0;
    chk("fullpop_level", 32'(bus.level_o), 32'd15);
    chk("fullpop_ovf",   32'(bus.ovf_o),   32'd1);
    chk("fullpop_pulse", 32'(bus.tx_e_o),  32'd1);
    bus.ovf_clr_i = 1'b1;
    @(negedge clk);
    bus.ovf_clr_i = 1'b0;
    chk("fullpop_ovf_clear", 32'(bus.ovf_o), 32'd0);

    // Busy never rises: each launch is abandoned after two cycles and the next follows.
    k = launched.size();
    for (int c = 0; c < 20 && launched.size() < k + 2; c++) @(negedge clk);
    chk("lost_launch_count", 32'(launched.size() >= k + 2), 32'd1);
    if (k >= 1 && launched.size() >= k + 2) begin
      chk("lost_launch_gap0", 32'(launch_cyc[k] - launch_cyc[k - 1]), 32'd3);
      chk("lost_launch_gap1", 32'(launch_cyc[k + 1] - launch_cyc[k]), 32'd3);
    end

    // Reset right after a launch: pulse drops at once, FIFO flushed, nothing relaunched.
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = (bus.tx_e_o === 1'b1);
    end
    chk("midrst_pulse_seen", 32'(seen), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_tx_e",  32'(bus.tx_e_o),  32'd0);
    chk("midrst_level", 32'(bus.level_o), 32'd0);
    chk("midrst_empty", 32'(bus.empty_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    n0     = launched.size();
    repeat (20) @(negedge clk);
    chk("midrst_no_launch", 32'(launched.size() - n0), 32'd0);
    chk("midrst_empty_after", 32'(bus.empty_o), 32'd1);

    // Handshake with the transmitter model: three bytes, proper gaps after busy falls.
    auto_mode = 1'b1;
    n0        = launched.size();
    for (int i = 0; i < 3; i++) begin
      bus.wr_data_i = 8'h31 + 8'(i);
      bus.wr_en_i   = 1'b1;
      @(negedge clk);
    end
    bus.wr_en_i = 1'b0;
    for (int c = 0; c < 200 && launched.size() < n0 + 3; c++) @(negedge clk);
    repeat (30) @(negedge clk);
    chk("hs_pulse_count", 32'(launched.size() - n0), 32'd3);
    for (int i = 0; i < 3 && n0 + i < launched.size(); i++) begin
      chk("hs_byte", 32'(launched[n0 + i]), 32'h31 + 32'(i));
      if (i > 0) begin
        chk("hs_busy_fell_between", 32'(launch_fall[n0 + i] > launch_cyc[n0 + i - 1]), 32'd1);
        chk("hs_gap_ge2", 32'(launch_cyc[n0 + i] - launch_fall[n0 + i] >= 2), 32'd1);
      end
    end

    // Random traffic against the model with the transmitter model in the loop.
    for (int c = 0; c < 400; c++) begin
      bus.wr_en_i   = ($urandom_range(0, 3) != 0);
      bus.wr_data_i = 8'($urandom_range(0, 255));
      bus.ovf_clr_i = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    bus.wr_en_i   = 1'b0;
    bus.ovf_clr_i = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
